// File: rtl/updown_scheduler.sv
// Two-requester up/down/load/clear counter with round-robin arbitration.
// Each accepted command spends one cycle in EXEC before it updates the counter.
module updown_scheduler #(
  parameter int unsigned WIDTH       = 32,
  parameter logic [63:0] RESET_VALUE = 64'd0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  output logic             req0_done,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             req1_done,
  output logic [WIDTH-1:0] value,
  output logic             wrap,
  output logic             grant_id
);

  localparam logic [WIDTH-1:0] RstVal = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One    = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {StIdle, StExec} state_e;

  state_e           state_q, state_d;
  logic             ptr_q;
  logic             grant_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] value_q, value_d;
  logic             wrap_q, wrap_d;
  logic             done0_q, done1_q;
  logic             grant;
  logic             accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_data;

  // Arbitration and handshake; ready is held low while reset is asserted.
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0_valid && req1_valid) grant = ptr_q;
        else                          grant = req1_valid;
        accept     = (req0_valid | req1_valid) & ~reset;
        req0_ready = accept & ~grant;
        req1_ready = accept & grant;
        if (accept) state_d = StExec;
      end
      StExec:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign sel_op   = grant ? req1_op : req0_op;
  assign sel_data = grant ? req1_data : req0_data;

  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    unique case (op_q)
      2'b00: begin
        value_d = value_q + One;
        wrap_d  = &value_q;
      end
      2'b01: begin
        value_d = value_q - One;
        wrap_d  = ~|value_q;
      end
      2'b10:   value_d = data_q;
      default: value_d = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      op_q    <= 2'b00;
      data_q  <= '0;
      value_q <= RstVal;
      wrap_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (state_q == StIdle && accept) begin
        op_q    <= sel_op;
        data_q  <= sel_data;
        grant_q <= grant;
        ptr_q   <= ~grant;
      end
      if (state_q == StExec) begin
        value_q <= value_d;
        wrap_q  <= wrap_d;
        done0_q <= ~grant_q;
        done1_q <= grant_q;
      end
    end
  end

  assign value     = value_q;
  assign wrap      = wrap_q;
  assign req0_done = done0_q;
  assign req1_done = done1_q;
  assign grant_id  = grant_q;

endmodule

// File: doc/updown_scheduler.md
UPDOWN_SCHEDULER -- requirements
Module: updown_scheduler

Interface
REQ-001 Parameter WIDTH, default 32: counter width in bits; the legal range is 2..64.
REQ-002 Parameter RESET_VALUE, default 0: counter value loaded on reset; the block uses its low WIDTH bits.
REQ-003 Port clock  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port req0_valid  input  1: requester 0 presents a command.
REQ-006 Port req0_op  input  2: requester 0 opcode: 00 up, 01 down, 10 load, 11 clear.
REQ-007 Port req0_data  input  WIDTH: requester 0 load operand; ignored for other opcodes.
REQ-008 Port req0_ready  output  1: requester 0 command accepted this cycle.
REQ-009 Port req0_done  output  1: single-cycle pulse when requester 0's command has taken effect.
REQ-010 Ports req1_valid, req1_op, req1_data, req1_ready, req1_done: same widths and meanings as REQ-005..REQ-009, for requester 1.
REQ-011 Port value  output  WIDTH: current counter value, driven directly from a register.
REQ-012 Port wrap  output  1: single-cycle pulse on modulo wrap-around.
REQ-013 Port grant_id  output  1: requester that owns the command currently in EXEC, or the last completed command.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and EXEC.
REQ-015 IDLE behaviour SHALL be as follows.
- The arbiter selects one requester among those with valid high.
- It drives that requester's ready high combinationally.
- It drives the other requester's ready low.
REQ-016 A transfer SHALL occur when valid and ready are both high on a clock edge.
- At that edge the op, data and requester id are latched, grant_id updates, and the FSM goes to EXEC.
REQ-017 If neither valid is high in IDLE, both readys SHALL be low and the FSM stays in IDLE.
REQ-018 Both readys SHALL be low throughout EXEC.
REQ-019 The EXEC edge SHALL apply the latched op to value.
- On the same edge it pulses the owner's done for the following cycle and returns to IDLE.
REQ-020 Throughput SHALL be one command per two cycles.
- Latency is one cycle from the accept edge to the value update.
REQ-021 Arbitration SHALL be round-robin, using a 1-bit priority pointer.
- With both valid, the pointer's requester wins.
- After every transfer, the pointer points to the non-granted requester.
- With only one valid, that requester wins regardless of the pointer.
REQ-022 Opcode 00 SHALL set value to value+1, modulo 2^WIDTH.
- wrap pulses when value was all-ones.
REQ-023 Opcode 01 SHALL set value to value-1, modulo 2^WIDTH.
- wrap pulses when value was zero.
REQ-024 Opcode 10 SHALL load the latched data into value; opcode 11 SHALL set value to zero.
- Neither opcode ever asserts wrap.
REQ-025 wrap and done SHALL be registered and high for exactly one cycle, aligned to the first cycle the new value is visible.
REQ-026 value SHALL change only on an EXEC edge or on reset.
REQ-027 A requester dropping valid while not ready SHALL have no effect.
- Operands are sampled only at the transfer edge.

Reset
REQ-028 Asserting reset SHALL take effect immediately, independent of clock.
- FSM goes to IDLE; value becomes RESET_VALUE; pointer points to requester 0.
- grant_id becomes 0; wrap, both done and both ready are 0.
REQ-029 Reset asserted while in EXEC SHALL discard the latched command.
- No done pulse and no wrap pulse are produced.
REQ-030 After reset deasserts, the first rising edge SHALL be able to accept a command.

Verification
REQ-031 The bench SHALL cover reset with WIDTH=32 and RESET_VALUE=5, then req0 op=00 once.
- Required response: value=5 after reset, value=6 two edges after valid, req0_done pulses once.
REQ-032 The bench SHALL cover value=0 with req1 op=01.
- Required response: value=0xFFFFFFFF, wrap=1 and req1_done=1 in the same single cycle.
REQ-033 The bench SHALL cover value=0xFFFFFFFF with req0 op=00.
- Required response: value=0 and wrap pulses once.
REQ-034 The bench SHALL cover both requesters valid continuously after reset, req0 op=00 and req1 op=01.
- Required response: grants alternate 0,1,0,1 and value alternates between RESET_VALUE+1 and RESET_VALUE.
REQ-035 The bench SHALL cover req0 op=10 with data=0x1234, then req1 op=11.
- Required response: value=0x1234, then value=0, and wrap stays 0.
REQ-036 The bench SHALL cover reset asserted mid-cycle while in EXEC with a pending op=10, data=0xAA.
- Required response: value=RESET_VALUE immediately, no done pulse, and the FSM is in IDLE.
